// File: rtl/alu_writeback.sv
// alu_writeback: 2-entry in-order buffer that writes ALU results to the register file
// and commits flags at retire.
module alu_writeback (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_result,
  input  logic       in_c,
  input  logic       in_z,
  input  logic       in_arith,
  input  logic [2:0] in_dest,
  input  logic       in_wr_en,
  input  logic       in_flag_en,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic [7:0] rf_wdata,
  input  logic       rf_ready,
  output logic       flags_c,
  output logic       flags_z,
  output logic       busy
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [7:0] result;
    logic       c;
    logic       z;
    logic       arith;
    logic [2:0] dest;
    logic       wr_en;
    logic       flag_en;
  } entry_t;
  state_t state;
  entry_t mem [2];
  entry_t head;
  logic   rp, wp, acc, ret;
  always_comb begin
    head     = mem[rp];
    in_ready = state != FULL;
    busy     = state != EMPTY;
    acc      = in_valid && in_ready;
    ret      = busy && (!head.wr_en || rf_ready);
    rf_we    = busy && head.wr_en;
    rf_waddr = rf_we ? head.dest : '0;
    rf_wdata = rf_we ? head.result : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rp      <= 1'b0;
      wp      <= 1'b0;
      mem[0]  <= '0;
      mem[1]  <= '0;
      flags_c <= 1'b0;
      flags_z <= 1'b0;
    end else begin
      if (acc) begin
        mem[wp] <= '{in_result, in_c, in_z, in_arith, in_dest, in_wr_en, in_flag_en};
        wp      <= ~wp;
      end
      if (ret) begin
        rp <= ~rp;
        if (head.flag_en) begin
          flags_z <= head.z;
          if (head.arith) flags_c <= head.c;
        end
      end
      // accept and retire together leave the occupancy unchanged
      if (acc && !ret) state <= (state == EMPTY) ? ONE : FULL;
      else if (ret && !acc) state <= (state == FULL) ? ONE : EMPTY;
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed scenarios plus randomized traffic against a queue-based model.
module tb_alu_writeback;
  logic       clk, rst_n, in_valid, in_ready, in_c, in_z, in_arith, in_wr_en, in_flag_en;
  logic [7:0] in_result, rf_wdata;
  logic [2:0] in_dest, rf_waddr;
  logic       rf_we, rf_ready, flags_c, flags_z, busy;
  int         n_vec = 0, n_err = 0;
  wire [15:0] obs = {rf_we, rf_waddr, rf_wdata, flags_c, flags_z, busy, in_ready};

  typedef struct {
    logic [7:0] r;
    logic c, z, ar;
    logic [2:0] d;
    logic we, fe;
  } ent_t;
  ent_t q[$];
  logic mc, mz;

  alu_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_c(in_c), .in_z(in_z), .in_arith(in_arith),
    .in_dest(in_dest), .in_wr_en(in_wr_en), .in_flag_en(in_flag_en),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags_c(flags_c), .flags_z(flags_z), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic [2:0] d, input logic we,
                       input logic fe, input logic ar, input logic c, input logic z);
    in_valid = v; in_result = r; in_dest = d; in_wr_en = we;
    in_flag_en = fe; in_arith = ar; in_c = c; in_z = z;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rf_ready = 1'b1;
    drive(1'b1, 8'hA5, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (obs !== 16'h0001) begin n_err++; $display("FAIL reset[%0d] obs=%h exp=0001", i, obs); end
      tick();
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_write();
    rst_n = 1'b1; rf_ready = 1'b1;
    drive(1'b1, 8'h5A, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (obs !== {1'b1, 3'd3, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL single_head obs=%h exp=%h", obs, {1'b1, 3'd3, 8'h5A, 4'b0011});
    end
    tick();
    n_vec++;
    if (obs !== {1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL single_retire obs=%h exp=%h", obs, {12'h000, 4'b1001});
    end
  endtask

  task automatic test_backpressure();
    rf_ready = 1'b0;
    drive(1'b1, 8'h11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (obs !== {1'b1, 3'd1, 8'h11, 4'b1011}) begin n_err++; $display("FAIL bp_first obs=%h", obs); end
    drive(1'b1, 8'h22, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (obs !== {1'b1, 3'd1, 8'h11, 4'b1010}) begin n_err++; $display("FAIL bp_full obs=%h", obs); end
    drive(1'b1, 8'h33, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (obs !== {1'b1, 3'd1, 8'h11, 4'b1010}) begin n_err++; $display("FAIL bp_stall[%0d] obs=%h", i, obs); end
    end
    in_valid = 1'b0; rf_ready = 1'b1;
    tick();
    n_vec++;
    if (obs !== {1'b1, 3'd2, 8'h22, 4'b1011}) begin n_err++; $display("FAIL bp_second obs=%h", obs); end
    tick();
    n_vec++;
    if (obs !== {12'h000, 4'b1001}) begin n_err++; $display("FAIL bp_drain obs=%h", obs); end
  endtask

  task automatic test_logical();
    rf_ready = 1'b1;
    drive(1'b1, 8'h00, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (obs !== {1'b1, 3'd4, 8'h00, 4'b1011}) begin n_err++; $display("FAIL logic_head obs=%h", obs); end
    tick();
    n_vec++;
    if (obs !== {12'h000, 4'b1101}) begin n_err++; $display("FAIL logic_flags obs=%h exp=000d", obs); end
  endtask

  task automatic test_nowrite();
    logic seen_we;
    rf_ready = 1'b0;
    drive(1'b1, 8'hFF, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    seen_we = rf_we;
    n_vec++;
    if (obs !== {12'h000, 4'b1111}) begin n_err++; $display("FAIL nowrite_head obs=%h exp=000f", obs); end
    tick();
    seen_we = seen_we | rf_we;
    n_vec++;
    if (obs !== {12'h000, 4'b0001}) begin n_err++; $display("FAIL nowrite_retire obs=%h exp=0001", obs); end
    n_vec++;
    if (seen_we !== 1'b0) begin n_err++; $display("FAIL nowrite_we seen=%b exp=0", seen_we); end
  endtask

  task automatic test_back_to_back();
    rf_ready = 1'b1;
    drive(1'b1, 8'h44, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (obs !== {1'b1, 3'd6, 8'h44, 4'b0011}) begin n_err++; $display("FAIL b2b_first obs=%h", obs); end
    drive(1'b1, 8'h55, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (obs !== {1'b1, 3'd2, 8'h55, 4'b0011}) begin n_err++; $display("FAIL b2b_second obs=%h", obs); end
    tick();
    n_vec++;
    if (obs !== {12'h000, 4'b1101}) begin n_err++; $display("FAIL b2b_flags obs=%h exp=000d", obs); end
  endtask

  task automatic test_reset_mid_stall();
    rf_ready = 1'b0;
    drive(1'b1, 8'h66, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h77, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (obs !== {1'b1, 3'd1, 8'h66, 4'b1110}) begin n_err++; $display("FAIL mid_full obs=%h", obs); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== 16'h0001) begin n_err++; $display("FAIL mid_async obs=%h exp=0001", obs); end
    rf_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (obs !== 16'h0001) begin n_err++; $display("FAIL mid_after obs=%h exp=0001", obs); end
  endtask

  task automatic test_random();
    logic acc, ret;
    ent_t h;
    q.delete(); mc = 1'b0; mz = 1'b0;
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      rf_ready = 1'($urandom_range(0, 2) != 0);
      acc = in_valid && q.size() < 2;
      ret = q.size() > 0 && (!q[0].we || rf_ready);
      h = '{in_result, in_c, in_z, in_arith, in_dest, in_wr_en, in_flag_en};
      tick();
      if (ret) begin
        ent_t o;
        o = q.pop_front();
        if (o.fe) begin mz = o.z; if (o.ar) mc = o.c; end
      end
      if (acc) q.push_back(h);
      begin
        logic eq;
        logic [15:0] exp;
        eq = q.size() > 0 && q[0].we;
        exp = {eq, eq ? q[0].d : 3'd0, eq ? q[0].r : 8'd0, mc, mz, q.size() != 0, q.size() < 2};
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs, exp); end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_logical();
    test_nowrite();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
